// File: rtl/vga_timing_gen.sv
// Purpose: parametrised VGA raster timing generator. It produces the pixel position,
//   blank and sync signals and the line/frame start strobes, all aligned to one cycle.
// Latency: outputs are registered one clk after the internal pixel tick. The first
//   pix_en after reset release arrives CLK_DIV clk after the last reset edge.
// Backpressure: enable=0 freezes every counter and registered output, and the strobes
//   drop to 0.
// Ports: clk/resetn (synchronous, active-low), enable; pix_en, x_pos, y_pos,
//   screen_area, blank_n, hsync, vsync, line_start, frame_start (all registered).
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int CLK_DIV  = 2,
  parameter int CW       = 10
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          enable,
  output logic          pix_en,
  output logic [CW-1:0] x_pos,
  output logic [CW-1:0] y_pos,
  output logic          screen_area,
  output logic          blank_n,
  output logic          hsync,
  output logic          vsync,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // A one-bit divider is kept even when CLK_DIV=1. In that case it simply stays at 0.
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG   = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEG   = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic          HS_ON    = (HS_POL != 0);
  localparam logic          VS_ON    = (VS_POL != 0);

  logic [DW-1:0] div_q, div_d;
  logic [CW-1:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic [CW-1:0] x_pos_q, x_pos_d, y_pos_q, y_pos_d;
  logic          screen_area_q, screen_area_d;
  logic          hsync_q, hsync_d, vsync_q, vsync_d;
  logic          pix_en_q, pix_en_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;
  logic          tick;

  always_comb begin
    tick          = enable && (div_q == DIV_LAST);
    div_d         = div_q;
    hcnt_d        = hcnt_q;
    vcnt_d        = vcnt_q;
    x_pos_d       = x_pos_q;
    y_pos_d       = y_pos_q;
    screen_area_d = screen_area_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    // Strobes are pure functions of this cycle's tick, so they fall to 0 during a stall.
    pix_en_d      = tick;
    line_start_d  = tick && (hcnt_q == '0);
    frame_start_d = tick && (hcnt_q == '0) && (vcnt_q == '0);

    if (enable) begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    end

    if (tick) begin
      // All decodes use the pre-increment counters. This keeps them aligned with x_pos/y_pos.
      x_pos_d       = hcnt_q;
      y_pos_d       = vcnt_q;
      screen_area_d = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
      hsync_d       = ((hcnt_q >= HS_BEG) && (hcnt_q < HS_END)) ? HS_ON : ~HS_ON;
      vsync_d       = ((vcnt_q >= VS_BEG) && (vcnt_q < VS_END)) ? VS_ON : ~VS_ON;

      if (hcnt_q == H_LAST) begin
        hcnt_d = '0;
        vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
      end else begin
        hcnt_d = hcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      div_q         <= '0;
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      x_pos_q       <= '0;
      y_pos_q       <= '0;
      screen_area_q <= 1'b0;
      hsync_q       <= ~HS_ON;
      vsync_q       <= ~VS_ON;
      pix_en_q      <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      x_pos_q       <= x_pos_d;
      y_pos_q       <= y_pos_d;
      screen_area_q <= screen_area_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      pix_en_q      <= pix_en_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign pix_en      = pix_en_q;
  assign x_pos       = x_pos_q;
  assign y_pos       = y_pos_q;
  assign screen_area = screen_area_q;
  assign blank_n     = screen_area_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised successor to the fixed 640x480 VGA sync generator. All porch, sync and active timings are parameters, with selectable sync polarity and an internal pixel-clock divider. It adds a synchronous active-low reset, an enable/stall input, and line/frame start strobes. It feeds the tile renderer and DAC interface with position, blank and sync signals that are all aligned to the same cycle.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, asserted level of hsync (0 = active-low)
VS_POL, 0, asserted level of vsync
CLK_DIV, 2, clk cycles per pixel (>=1)
CW, 10, counter/position width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
clk  in  1  system clock; all logic on rising edge
resetn  in  1  synchronous reset, active-low
enable  in  1  run when 1; freezes all state when 0
pix_en  out  1  one-clk strobe, high in each cycle new pixel outputs appear
x_pos  out  CW  horizontal position of current outputs
y_pos  out  CW  vertical position of current outputs
screen_area  out  1  1 when x_pos<H_ACTIVE and y_pos<V_ACTIVE
blank_n  out  1  equals screen_area
hsync  out  1  horizontal sync at HS_POL polarity
vsync  out  1  vertical sync at VS_POL polarity
line_start  out  1  one-clk strobe with pix_en when x_pos==0
frame_start  out  1  one-clk strobe with pix_en when x_pos==0 and y_pos==0

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. V_TOTAL is the same sum over the V_* parameters. Defaults give 800 x 525.
- Divider counter div runs 0..CLK_DIV-1 while enable=1. Internal tick = enable && div==CLK_DIV-1. When CLK_DIV=1, tick = enable.
- On tick:
  - hcnt increments and wraps H_TOTAL-1 -> 0.
  - On that wrap, vcnt increments and wraps V_TOTAL-1 -> 0.
  - The simultaneous wrap at (H_TOTAL-1, V_TOTAL-1) goes to (0,0).
- Output register stage: on tick, x_pos/y_pos <= pre-increment hcnt/vcnt. All decoded outputs are computed from those same pre-increment values, so every output is mutually aligned with x_pos/y_pos.
- pix_en is the registered tick: high exactly one clk after tick, for one clk.
- hsync = HS_POL when x_pos in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), else ~HS_POL.
- vsync = VS_POL when y_pos in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), else ~VS_POL.
- line_start and frame_start are high only in the pix_en cycle; otherwise 0.
- enable=0: div, hcnt, vcnt and all registered outputs hold. pix_en, line_start and frame_start are 0.
- If enable drops mid-divide, div resumes from its held value.
- Reset (resetn=0 at a clk edge, regardless of enable), including mid-frame:
  - div=0, hcnt=0, vcnt=0, x_pos=0, y_pos=0.
  - screen_area=0, blank_n=0, pix_en=0, line_start=0, frame_start=0.
  - hsync=~HS_POL, vsync=~VS_POL.
- After reset release, the first pix_en presents (0,0) with frame_start=1, CLK_DIV clk cycles after the release edge.
- No combinational path from inputs to outputs. Counters never exceed TOTAL-1.

Test Plan:
- Reset/startup, defaults, CLK_DIV=1: hold resetn=0 for 3 clk with enable=1 -> all outputs at reset values (hsync=1, vsync=1). After release, first pix_en cycle shows x_pos=0, y_pos=0, frame_start=1, line_start=1, blank_n=1.
- Line timing, CLK_DIV=1: count pix_en between line_start strobes -> 800. blank_n high for x_pos 0..639. hsync=0 for exactly 96 pixels, x_pos 656..751.
- Frame timing: frame_start period = 420000 pixel strobes. vsync=0 only on y_pos 490..491. blank_n=0 for all y_pos>=480.
- Divider, CLK_DIV=2: pix_en high every other clk. Line period = 1600 clk. Outputs stable between strobes.
- Stall and mid-frame reset: deassert enable at x_pos=300 for 50 clk -> outputs frozen, no strobes; then resumes at x_pos=301. Pulse resetn=0 at (400,200) -> next pix_en shows (0,0) with frame_start.
- Override (H 8/2/3/1, V 4/1/1/1, HS_POL=1, VS_POL=1, CLK_DIV=3): H_TOTAL=14, V_TOTAL=7. hsync=1 on x_pos 10..12. vsync=1 on y_pos 5. Wrap (13,6) -> (0,0) with frame_start.
